ps2_paddle_keys: RTL and testbench

PS/2 keyboard receiver and key-state decoder that drives the eight paddle direction inputs of the VGA pong controller. It samples the `ps2_clk`/`ps2_data` pins on the 100 MHz system clock, deframes 11-bit PS/2 device-to-host frames, and tracks E0 (extended) and F0 (break) prefixes. It maintains a held/released level for each of eight movement keys. Its level outputs connect directly to `p1_up` … `p2_right` of the VGA controller.

---
 rtl/ps2_paddle_keys.sv | 236 +++++++++++++++++++++++
 tb/tb_ps2_paddle_keys.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_paddle_keys.sv
// rtl/ps2_paddle_keys.sv - PS/2 keyboard receiver and paddle key-state decoder
//
// Receives 11-bit PS/2 device-to-host frames, tracks E0 (extended) and F0
// (break) prefixes and keeps a held/released level for eight movement keys.
//
// Optional feature macro: PS2_PARITY_CHECK_EN
//   defined   - odd parity over data+parity is checked; a mismatch rejects the frame
//   undefined - parity bit is sampled and ignored
//
// Parameters:
//   TIMEOUT_CYCLES  system clocks without a ps2_clk falling edge mid-frame before abort
// Ports:
//   clk          system clock, all logic on posedge
//   reset        asynchronous active-high reset
//   ps2_clk      PS/2 clock pin, read only (never driven)
//   ps2_data     PS/2 data pin, read only (never driven)
//   p1_up..p1_right  held levels for W, S, A, D
//   p2_up..p2_right  held levels for arrow Up, Down, Left, Right
//   scan_code    last accepted non-prefix scancode
//   scan_valid   one-cycle pulse when scan_code updates
//   frame_err    one-cycle pulse on a rejected or timed-out frame
module ps2_paddle_keys #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    inout  wire        ps2_clk,
    inout  wire        ps2_data,
    output logic       p1_up,
    output logic       p1_down,
    output logic       p1_left,
    output logic       p1_right,
    output logic       p2_up,
    output logic       p2_down,
    output logic       p2_left,
    output logic       p2_right,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err
);

    localparam logic [16:0] TIMEOUT_CNT = 17'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Pin conditioning. Synchronizers reset to 1 (idle bus level) so that
    // leaving reset can never look like a falling edge.
    logic [1:0] clk_sync;
    logic [1:0] data_sync;
    logic       clk_hist;
    logic       fe;
    logic       din;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_hist  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_hist  <= clk_sync[1];
        end
    end

    assign fe  = clk_hist & ~clk_sync[1];
    assign din = data_sync[1];

    // Frame FSM
    state_t      state;
    state_t      state_next;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic [16:0] idle_cnt;
    logic        timeout;
    logic        edge_take;
    logic        par_ok;
    logic [7:0]  byte_q;
    logic        byte_ok;
    logic        byte_bad;

    assign timeout   = (state != S_IDLE) && (idle_cnt == TIMEOUT_CNT);
    // Timeout has priority over an edge arriving on the same clock.
    assign edge_take = fe & ~timeout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (timeout) begin
            state_next = S_IDLE;
        end else if (fe) begin
            case (state)
                S_IDLE:   if (!din) state_next = S_DATA;
                S_DATA:   if (bit_cnt == 3'd7) state_next = S_PARITY;
                S_PARITY: state_next = S_STOP;
                S_STOP:   state_next = S_IDLE;
                default:  state_next = S_IDLE;
            endcase
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    logic par_bit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_bit <= 1'b0;
        end else if (edge_take && state == S_PARITY) begin
            par_bit <= din;
        end
    end

    assign par_ok = ^{shift, par_bit};
`else
    assign par_ok = 1'b1;
`endif

    // Deframing datapath. An accepted or rejected byte is handed to the
    // decode stage one clock after the stop-bit edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt  <= 3'd0;
            shift    <= 8'h00;
            idle_cnt <= 17'd0;
            byte_q   <= 8'h00;
            byte_ok  <= 1'b0;
            byte_bad <= 1'b0;
        end else begin
            byte_ok  <= 1'b0;
            byte_bad <= 1'b0;

            if (timeout || fe) begin
                idle_cnt <= 17'd0;
            end else if (state != S_IDLE) begin
                idle_cnt <= idle_cnt + 17'd1;
            end

            if (edge_take) begin
                case (state)
                    S_IDLE: begin
                        bit_cnt <= 3'd0;
                    end
                    S_DATA: begin
                        shift[bit_cnt] <= din;
                        bit_cnt        <= bit_cnt + 3'd1;
                    end
                    S_STOP: begin
                        byte_q <= shift;
                        if (din && par_ok) begin
                            byte_ok <= 1'b1;
                        end else begin
                            byte_bad <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Key lookup: bit order of keys is p1 up/down/left/right, then p2.
    logic       ext;
    logic       brk;
    logic [7:0] keys;
    logic       key_hit;
    logic [2:0] key_idx;

    always_comb begin
        key_hit = 1'b1;
        key_idx = 3'd0;
        if (!ext) begin
            case (byte_q)
                8'h1D:   key_idx = 3'd0;
                8'h1B:   key_idx = 3'd1;
                8'h1C:   key_idx = 3'd2;
                8'h23:   key_idx = 3'd3;
                default: key_hit = 1'b0;
            endcase
        end else begin
            case (byte_q)
                8'h75:   key_idx = 3'd4;
                8'h72:   key_idx = 3'd5;
                8'h6B:   key_idx = 3'd6;
                8'h74:   key_idx = 3'd7;
                default: key_hit = 1'b0;
            endcase
        end
    end

    // Byte decode. Prefix flags survive a timeout; only a completed
    // non-prefix byte clears them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext        <= 1'b0;
            brk        <= 1'b0;
            keys       <= 8'h00;
            scan_code  <= 8'h00;
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            scan_valid <= 1'b0;
            frame_err  <= byte_bad | timeout;
            if (byte_ok) begin
                if (byte_q == 8'hE0) begin
                    ext <= 1'b1;
                end else if (byte_q == 8'hF0) begin
                    brk <= 1'b1;
                end else begin
                    scan_code  <= byte_q;
                    scan_valid <= 1'b1;
                    if (key_hit) begin
                        keys[key_idx] <= ~brk;
                    end
                    ext <= 1'b0;
                    brk <= 1'b0;
                end
            end
        end
    end

    assign {p2_right, p2_left, p2_down, p2_up, p1_right, p1_left, p1_down, p1_up} = keys;

endmodule

// File: tb/tb_ps2_paddle_keys.sv
// tb/tb_ps2_paddle_keys.sv - self-checking bench for ps2_paddle_keys
module tb_ps2_paddle_keys;

    localparam int T_OUT = 200;

    logic clk      = 1'b0;
    logic reset    = 1'b1;
    logic drv_clk  = 1'b1;
    logic drv_data = 1'b1;
    wire  ps2_clk_w;
    wire  ps2_data_w;
    assign ps2_clk_w  = drv_clk;
    assign ps2_data_w = drv_data;

    logic       p1_up, p1_down, p1_left, p1_right;
    logic       p2_up, p2_down, p2_left, p2_right;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       frame_err;

    ps2_paddle_keys #(.TIMEOUT_CYCLES(T_OUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk_w),
        .ps2_data   (ps2_data_w),
        .p1_up      (p1_up),
        .p1_down    (p1_down),
        .p1_left    (p1_left),
        .p1_right   (p1_right),
        .p2_up      (p2_up),
        .p2_down    (p2_down),
        .p2_left    (p2_left),
        .p2_right   (p2_right),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    wire [7:0] dut_keys = {p2_right, p2_left, p2_down, p2_up, p1_right, p1_left, p1_down, p1_up};

    int checks = 0;
    int errors = 0;
    int half   = 6;

    // Behavioural model: key table, prefix flags, pending output event.
    logic [7:0] key_codes [8] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h75, 8'h72, 8'h6B, 8'h74};
    logic [7:0] m_keys = 8'h00;
    logic [7:0] m_code = 8'h00;
    bit         m_ext  = 1'b0;
    bit         m_brk  = 1'b0;

    int         pend_cyc  = -1;
    logic [7:0] pend_keys = 8'h00;
    logic [7:0] pend_code = 8'h00;
    bit         pend_sv   = 1'b0;
    bit         pend_fe   = 1'b0;

    logic [7:0] exp_keys = 8'h00;
    logic [7:0] exp_code = 8'h00;
    bit         exp_sv;
    bit         exp_fe;
    bit         fe_mask  = 1'b0;
    int         fe_count = 0;

    int         pin_seq  = 0;
    int         pin_seen = 0;
    logic [7:0] pin_keys = 8'h00;
    logic [7:0] pin_code = 8'h00;
    int         pin_fec  = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Compare process: every cycle, DUT against model; pins check model and DUT against literals.
    always @(negedge clk) begin
        exp_sv = 1'b0;
        exp_fe = 1'b0;
        if (reset) begin
            exp_keys = 8'h00;
            exp_code = 8'h00;
        end else if (cyc == pend_cyc) begin
            exp_keys = pend_keys;
            exp_code = pend_code;
            exp_sv   = pend_sv;
            exp_fe   = pend_fe;
        end
        if (frame_err === 1'b1) fe_count++;
        check("keys", 32'(dut_keys), 32'(exp_keys));
        check("scan_code", 32'(scan_code), 32'(exp_code));
        check("scan_valid", 32'(scan_valid), 32'(exp_sv));
        if (!fe_mask) check("frame_err", 32'(frame_err), 32'(exp_fe));
        if (pin_seq != pin_seen) begin
            pin_seen = pin_seq;
            check("pin_model_keys", 32'(exp_keys), 32'(pin_keys));
            check("pin_dut_keys", 32'(dut_keys), 32'(pin_keys));
            check("pin_dut_code", 32'(scan_code), 32'(pin_code));
            if (pin_fec >= 0) check("pin_frame_err_count", 32'(fe_count), 32'(pin_fec));
        end
    end

    task automatic model_reset();
        m_keys = 8'h00;
        m_code = 8'h00;
        m_ext  = 1'b0;
        m_brk  = 1'b0;
    endtask

    task automatic model_frame(input logic [7:0] b, input logic par, input logic stop, input int fall_c);
        bit ok;
`ifdef PS2_PARITY_CHECK_EN
        ok = stop && (^{b, par});
`else
        ok = stop;
`endif
        pend_fe = !ok;
        pend_sv = 1'b0;
        if (ok) begin
            if (b == 8'hE0) begin
                m_ext = 1'b1;
            end else if (b == 8'hF0) begin
                m_brk = 1'b1;
            end else begin
                m_code  = b;
                pend_sv = 1'b1;
                for (int k = 0; k < 8; k++) begin
                    if (key_codes[k] == b && ((k >= 4) == m_ext)) m_keys[k] = !m_brk;
                end
                m_ext = 1'b0;
                m_brk = 1'b0;
            end
        end
        pend_keys = m_keys;
        pend_code = m_code;
        pend_cyc  = fall_c + 4;
    endtask

    task automatic ps2_bit(input logic b);
        drv_data = b;
        repeat (half) @(posedge clk);
        #1 drv_clk = 1'b0;
        repeat (half) @(posedge clk);
        #1 drv_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input logic stop);
        logic par;
        int   fall_c;
        par = ~^b;
        if (bad_par) par = ~par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        drv_data = stop;
        repeat (half) @(posedge clk);
        #1 drv_clk = 1'b0;
        fall_c = cyc;
        model_frame(b, par, stop, fall_c);
        repeat (half) @(posedge clk);
        #1 drv_clk = 1'b1;
        drv_data = 1'b1;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic send_ok(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b1);
    endtask

    task automatic pin(input logic [7:0] k, input logic [7:0] c, input int fec);
        pin_keys = k;
        pin_code = c;
        pin_fec  = fec;
        pin_seq++;
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   fec0;
        logic [7:0] part;
        logic [7:0] b;
        int   r;

        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        pin(8'h00, 8'h00, 0);

        send_ok(8'h1D);
        pin(8'h01, 8'h1D, 0);
        send_ok(8'hF0); send_ok(8'h1D);
        pin(8'h00, 8'h1D, 0);

        send_ok(8'hE0); send_ok(8'h75);
        pin(8'h10, 8'h75, 0);
        send_ok(8'hE0); send_ok(8'hF0); send_ok(8'h75);
        pin(8'h00, 8'h75, 0);

        send_frame(8'h1C, 1'b1, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
        pin(8'h00, 8'h75, 1);
`else
        pin(8'h04, 8'h1C, 0);
`endif
        send_ok(8'hF0); send_ok(8'h1C);
        pin(8'h00, 8'h1C, -1);

        // Timeout: start bit plus four data bits, then silence.
        fe_mask = 1'b1;
        fec0 = fe_count;
        part = 8'h23;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(part[i]);
        drv_data = 1'b1;
        repeat (T_OUT + 40) @(posedge clk);
        #1 fe_mask = 1'b0;
        pin(8'h00, 8'h1C, fec0 + 1);
        send_ok(8'h23);
        pin(8'h08, 8'h23, -1);

        send_ok(8'h1B); send_ok(8'hE0); send_ok(8'h6B);
        pin(8'h4A, 8'h6B, -1);
        send_ok(8'hF0); send_ok(8'h1B);
        pin(8'h48, 8'h1B, -1);

        // Reset in the middle of a frame.
        part = 8'h1B;
        ps2_bit(1'b0);
        ps2_bit(part[0]);
        ps2_bit(part[1]);
        reset = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        pin(8'h00, 8'h00, -1);
        send_ok(8'h1B);
        pin(8'h02, 8'h1B, -1);

        fec0 = fe_count;
        send_frame(8'h1D, 1'b0, 1'b0);
        pin(8'h02, 8'h1B, fec0 + 1);

        send_ok(8'hE0); send_ok(8'h1D);
        pin(8'h02, 8'h1D, -1);
        send_ok(8'h75);
        pin(8'h02, 8'h75, -1);

        // Randomized traffic against the model.
        for (int n = 0; n < 80; n++) begin
            half = $urandom_range(4, 8);
            r = $urandom_range(0, 9);
            if (r < 6)       b = key_codes[$urandom_range(0, 7)];
            else if (r == 6) b = 8'hE0;
            else if (r == 7) b = 8'hF0;
            else             b = 8'($urandom_range(0, 255));
            send_frame(b, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) != 0));
        end

        repeat (10) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
